// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared FSM state encoding and default geometry for fifo_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int c_DEF_ADDR_WIDTH = 3;
  localparam int c_DEF_DEPTH      = 8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_NORMAL = 2'b01,
    ST_FULL   = 2'b10
  } fifo_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module  : fifo_ctrl
// Brief   : Pointer/flag controller for an external FIFO memory (memoria).
//           Optional sticky overflow/underflow flag under macro FIFO_ERROR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
  parameter int DEPTH      = c_DEF_DEPTH,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERROR_EN
  output logic                  fifo_error,
`endif
  output logic [ADDR_WIDTH:0]   fifo_count
);

  localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_AF        = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_AE        = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] c_LAST      = ADDR_WIDTH'(DEPTH - 1);

  fifo_state_t           r_state;
  fifo_state_t           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_dv;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  function automatic logic [ADDR_WIDTH-1:0] f_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign w_pop_ok  = pop & (r_state != ST_EMPTY);
  assign w_push_ok = push & ((r_state != ST_FULL) | w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    if (w_count_nxt == '0)
      w_state_nxt = ST_EMPTY;
    else if (w_count_nxt == c_DEPTH_CNT)
      w_state_nxt = ST_FULL;
    else
      w_state_nxt = ST_NORMAL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_dv     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_af    <= (w_count_nxt >= c_AF);
      r_ae    <= (w_count_nxt <= c_AE);
      r_dv    <= w_pop_ok;
      if (w_push_ok) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= f_inc(r_rd_ptr);
    end
  end

`ifdef FIFO_ERROR_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if ((push & ~pop & (r_state == ST_FULL)) | (pop & (r_state == ST_EMPTY)))
      r_err <= 1'b1;
  end

  assign fifo_error = r_err;
`endif

  // Strobes are gated by reset so memoria never sees a write during an abort.
  assign write_enable = w_push_ok & ~reset;
  assign read_enable  = w_pop_ok & ~reset;
  assign wr_ptr       = r_wr_ptr;
  assign rd_ptr       = r_rd_ptr;
  assign fifo_count   = r_count;
  assign data_valid   = r_dv;
  assign empty        = (r_state == ST_EMPTY);
  assign full         = (r_state == ST_FULL);
  assign almost_full  = r_af;
  assign almost_empty = r_ae;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
// Module  : tb_fifo_ctrl
// Brief   : Randomized self-checking bench for fifo_ctrl with a queue model
//           and a small memoria stand-in. Honours FIFO_ERROR_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          write_enable;
  logic          read_enable;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   fifo_count;
`ifdef FIFO_ERROR_EN
  logic          fifo_error;
`endif

  logic [11:0]   wdata;
  logic [11:0]   rdata;
  logic [11:0]   mem [DEPTH];

  int            n_tests;
  int            n_fail;

  int            m_wp;
  int            m_rp;
  bit            m_dv;
  bit            m_err;
  logic [11:0]   m_exp_data;
  logic [11:0]   m_q[$];

  fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERROR_EN
    .fifo_error   (fifo_error),
`endif
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memoria stand-in: synchronous write, one-cycle read latency
  always @(posedge clk) begin
    if (write_enable) mem[wr_ptr] <= wdata;
    if (read_enable)  rdata <= mem[rd_ptr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wp  = 0;
    m_rp  = 0;
    m_dv  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs();
    int c;
    c = m_q.size();
    check("fifo_count",   32'(fifo_count),   32'(c));
    check("full",         32'(full),         32'(c == DEPTH));
    check("empty",        32'(empty),        32'(c == 0));
    check("almost_full",  32'(almost_full),  32'(c >= AF));
    check("almost_empty", 32'(almost_empty), 32'(c <= AE));
    check("wr_ptr",       32'(wr_ptr),       32'(m_wp));
    check("rd_ptr",       32'(rd_ptr),       32'(m_rp));
    check("data_valid",   32'(data_valid),   32'(m_dv));
    if (m_dv) check("read_data", 32'(rdata), 32'(m_exp_data));
`ifdef FIFO_ERROR_EN
    check("fifo_error",   32'(fifo_error),   32'(m_err));
`endif
  endtask

  // Called at posedge+1; drives one cycle of requests and checks both phases.
  task automatic step(input bit p, input bit q, input logic [11:0] d);
    bit pop_ok;
    bit push_ok;
    int c;
    c     = m_q.size();
    push  = p;
    pop   = q;
    wdata = d;
    #2;
    pop_ok  = q && (c > 0);
    push_ok = p && ((c < DEPTH) || pop_ok);
    check("write_enable", 32'(write_enable), 32'(push_ok));
    check("read_enable",  32'(read_enable),  32'(pop_ok));
    if (push_ok) check("write_addr", 32'(wr_ptr), 32'(m_wp));
    if ((p && !q && c == DEPTH) || (q && c == 0)) m_err = 1'b1;
    if (pop_ok)  m_exp_data = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    if (push_ok) m_wp = (m_wp + 1) % DEPTH;
    if (pop_ok)  m_rp = (m_rp + 1) % DEPTH;
    m_dv = pop_ok;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int pp;
    int qp;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    wdata   = '0;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();

    // fill to full, then overflow attempt, then push+pop at full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 12'($urandom));
    step(1'b1, 1'b0, 12'h111);
    step(1'b1, 1'b1, 12'h222);
    // drain, then pop on empty alone and with a push
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 12'h0);
    step(1'b0, 1'b1, 12'h0);
    step(1'b1, 1'b1, 12'h333);
    step(1'b0, 1'b1, 12'h0);
    step(1'b1, 1'b0, 12'hA5A);
    step(1'b0, 1'b1, 12'h0);
    step(1'b0, 1'b0, 12'h0);

    // asynchronous reset in the middle of a burst at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'($urandom));
    push = 1'b1;
    pop  = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check("wen_in_reset", 32'(write_enable), 32'd0);
    check("ren_in_reset", 32'(read_enable),  32'd0);
    check_outputs();
    push = 1'b0;
    pop  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();
    step(1'b1, 1'b0, 12'h5C3);

    // randomized traffic with phases biased toward full, empty and balanced
    for (int i = 0; i < 600; i++) begin
      case ((i / 50) % 3)
        0:       begin pp = 80; qp = 25; end
        1:       begin pp = 25; qp = 80; end
        default: begin pp = 55; qp = 55; end
      endcase
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < qp, 12'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
